// File: rtl/tap_timebase_if.sv
`timescale 1ns/1ps
// Control and strobe bundle between tap_timebase and its consumers.
// The master drives en/clr, and the timebase drives taps/wrap/cnt back.
interface tap_timebase_if #(
    parameter int WIDTH = 27,
    parameter int NTAPS = 6
);
    logic             en;
    logic             clr;
    logic [NTAPS-1:0] taps;
    logic             wrap;
    logic [WIDTH-1:0] cnt;

    modport master (
        output en,
        output clr,
        input  taps,
        input  wrap,
        input  cnt
    );

    modport slave (
        input  en,
        input  clr,
        output taps,
        output wrap,
        output cnt
    );
endinterface

// File: rtl/tap_timebase.sv
`timescale 1ns/1ps
// Free-running counter that emits power-of-two tap strobes and a rollover strobe.
// Latency: strobes register on the same edge as cnt, so a strobe coincides with the cnt value that raised its bit.
// Backpressure: none; en=0 freezes cnt and silences strobes, while clr or rst zero everything.
module tap_timebase #(
    parameter int WIDTH = 27,
    parameter int NTAPS = 6
) (
    input  logic          clk,
    input  logic          rst,
    tap_timebase_if.slave bus
);
    generate
        if (NTAPS < 2 || WIDTH < NTAPS) begin : g_param_check
            $error("tap_timebase: requires NTAPS >= 2 and WIDTH >= NTAPS");
        end
    endgenerate

    // Tap i sits on bit (i*(WIDTH-1))/(NTAPS-1); every tap consumer uses this same mapping.
    function automatic int tap_bit(input int idx);
        return (idx * (WIDTH - 1)) / (NTAPS - 1);
    endfunction

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] rise;
    logic [NTAPS-1:0] taps_q;
    logic [NTAPS-1:0] taps_d;
    logic             wrap_q;

    assign cnt_inc = cnt_q + WIDTH'(1);
    // Exactly one bit goes 0->1 per increment, and none does on rollover.
    assign rise    = cnt_inc & ~cnt_q;

    for (genvar i = 0; i < NTAPS; i++) begin : g_tap
        localparam int K = tap_bit(i);
        assign taps_d[i] = rise[K];
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            cnt_q  <= '0;
            taps_q <= '0;
            wrap_q <= 1'b0;
        end else if (bus.en) begin
            cnt_q  <= cnt_inc;
            taps_q <= taps_d;
            wrap_q <= &cnt_q;
        end else begin
            taps_q <= '0;
            wrap_q <= 1'b0;
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.taps = taps_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_tap_timebase.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for tap_timebase (8-bit/3-tap instance) plus a default-parameter run.
module tb_tap_timebase;
    localparam int KB [3]  = '{0, 3, 7};
    localparam int KD [6]  = '{0, 5, 10, 15, 20, 26};

    logic clk = 1'b0;
    logic rst;
    logic rst27;
    always #5 clk = ~clk;

    tap_timebase_if #(.WIDTH(8),  .NTAPS(3)) tb_if ();
    tap_timebase_if #(.WIDTH(27), .NTAPS(6)) if27 ();

    tap_timebase #(.WIDTH(8), .NTAPS(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (tb_if)
    );

    tap_timebase #(.WIDTH(27), .NTAPS(6)) u_dut27 (
        .clk (clk),
        .rst (rst27),
        .bus (if27)
    );

    typedef struct {
        logic [7:0] cnt;
        logic [2:0] taps;
        logic       wrap;
        bit         run;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt  = 0;
    bit   done27 = 1'b0;

    // Reference: a plain integer counter; bit k rises when the new value mod 2^(k+1) equals 2^k.
    task automatic step(input bit r, input bit c, input bit e);
        exp_t x;
        @(negedge clk);
        rst       = r;
        tb_if.clr = c;
        tb_if.en  = e;
        x.taps = '0;
        x.wrap = 1'b0;
        if (r || c) begin
            m_cnt = 0;
        end else if (e) begin
            x.wrap = (m_cnt == 255);
            m_cnt  = (m_cnt + 1) % 256;
            for (int i = 0; i < 3; i++)
                x.taps[i] = ((m_cnt % (1 << (KB[i] + 1))) == (1 << KB[i]));
        end
        x.cnt = m_cnt[7:0];
        x.run = !r && !c && e;
        sb_q.push_back(x);
    endtask

    // Monitor: one expectation per clock edge, plus period checks over uninterrupted runs.
    int cyc = 0;
    int tlast [4];
    bit tvalid [4];
    initial begin
        exp_t e;
        for (int i = 0; i < 4; i++) tvalid[i] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                cyc++;
                checks++;
                if (tb_if.cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL cnt: cycle %0d got %0d expected %0d", cyc, tb_if.cnt, e.cnt);
                end
                checks++;
                if (tb_if.taps !== e.taps) begin
                    errors++;
                    $display("FAIL taps: cycle %0d cnt %0d got %b expected %b", cyc, e.cnt, tb_if.taps, e.taps);
                end
                checks++;
                if (tb_if.wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL wrap: cycle %0d cnt %0d got %b expected %b", cyc, e.cnt, tb_if.wrap, e.wrap);
                end
                if (tb_if.taps != 3'b000) begin
                    checks++;
                    if (!$onehot(tb_if.taps)) begin
                        errors++;
                        $display("FAIL onehot: cycle %0d taps %b", cyc, tb_if.taps);
                    end
                end
                if (!e.run) begin
                    for (int i = 0; i < 4; i++) tvalid[i] = 1'b0;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if ((i < 3) ? (tb_if.taps[i] === 1'b1) : (tb_if.wrap === 1'b1)) begin
                            if (tvalid[i]) begin
                                checks++;
                                if (cyc - tlast[i] != ((i < 3) ? (1 << (KB[i] + 1)) : 256)) begin
                                    errors++;
                                    $display("FAIL period%0d: got %0d expected %0d", i, cyc - tlast[i],
                                             (i < 3) ? (1 << (KB[i] + 1)) : 256);
                                end
                            end
                            tlast[i]  = cyc;
                            tvalid[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Default-parameter instance: free run from reset, checked against the integer model.
    initial begin
        int n;
        int first2;
        int last1;
        logic [5:0] exp_t27;
        rst27    = 1'b1;
        if27.en  = 1'b0;
        if27.clr = 1'b0;
        n = 0;
        first2 = -1;
        last1 = -1;
        repeat (2) @(negedge clk);
        rst27   = 1'b0;
        if27.en = 1'b1;
        for (int c = 0; c < 4096; c++) begin
            @(posedge clk);
            #1;
            n++;
            for (int i = 0; i < 6; i++)
                exp_t27[i] = ((n % (1 << (KD[i] + 1))) == (1 << KD[i]));
            checks++;
            if (if27.cnt !== 27'(n) || if27.taps !== exp_t27) begin
                errors++;
                $display("FAIL dflt: cnt %0d taps %b expected cnt %0d taps %b", if27.cnt, if27.taps, n, exp_t27);
            end
            if (if27.taps[1] === 1'b1) begin
                if (last1 >= 0) begin
                    checks++;
                    if (n - last1 != 64) begin
                        errors++;
                        $display("FAIL dflt_period1: got %0d expected 64", n - last1);
                    end
                end
                last1 = n;
            end
            if (if27.taps[2] === 1'b1 && first2 < 0) first2 = int'(if27.cnt);
        end
        checks++;
        if (first2 != 1024) begin
            errors++;
            $display("FAIL dflt_first_tap2: got %0d expected 1024", first2);
        end
        done27 = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        tb_if.en  = 1'b0;
        tb_if.clr = 1'b0;
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (600) step(0, 0, 1);
        // Stall at cnt=7, then resume; the first enabled edge must fire tap 1 at cnt=8.
        step(1, 0, 0);
        repeat (7) step(0, 0, 1);
        repeat (10) step(0, 0, 0);
        repeat (4) step(0, 0, 1);
        while (m_cnt != 127) step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(1, 1, 1);
        while (m_cnt != 200) step(0, 0, 1);
        step(1, 0, 1);
        repeat (3) step(0, 0, 1);
        repeat (3000) begin
            int r;
            r = $urandom_range(0, 999);
            step(r < 4, (r >= 4 && r < 12), ($urandom_range(0, 99) < 85));
        end
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left", sb_q.size());
        end
        for (int i = 0; i < 10000 && !done27; i++) @(posedge clk);
        #2;
        checks++;
        if (!done27) begin
            errors++;
            $display("FAIL dflt_done: default-parameter run did not finish");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
